// File: rtl/regfile_pkg.sv
// Shared types and constants for the int/float register file with scoreboard.
package regfile_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int NREG_DEFAULT = 32;

    localparam logic BANK_INT = 1'b0;
    localparam logic BANK_FLT = 1'b1;

    typedef enum logic {RF_INIT, RF_RUN} rf_state_t;

endpackage

// File: rtl/regfile_bank.sv
// One register bank: storage, prioritised write ports, clear port and bypassing reads.
// ZERO_REG0 hardwires index 0 to zero (integer bank).
module regfile_bank
    import regfile_pkg::*;
#(
    parameter int XLEN      = XLEN_DEFAULT,
    parameter int NREG      = NREG_DEFAULT,
    parameter int NRD       = 3,
    parameter int NWR       = 2,
    parameter bit ZERO_REG0 = 1'b0,
    localparam int RW       = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 clr_en,
    input  logic [RW-1:0]        clr_idx,
    input  logic [NWR-1:0]       wr_en,
    input  logic [NWR*RW-1:0]    wr_reg,
    input  logic [NWR*XLEN-1:0]  wr_data,
    input  logic [NRD*RW-1:0]    rd_reg,
    output logic [NRD*XLEN-1:0]  rd_data,
    output logic [NRD-1:0]       rd_hit
);

    logic [XLEN-1:0] mem [NREG];

    // Later write ports are applied last, so the highest-index port wins on collision.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem[clr_idx] <= '0;
        end else begin
            for (int p = 0; p < NWR; p++) begin
                if (wr_en[p] && !(ZERO_REG0 && wr_reg[p*RW +: RW] == '0)) begin
                    mem[wr_reg[p*RW +: RW]] <= wr_data[p*XLEN +: XLEN];
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [RW-1:0]   idx;
            logic [XLEN-1:0] val;
            logic            hit;

            assign idx = rd_reg[gi*RW +: RW];

            always_comb begin
                val = mem[idx];
                hit = 1'b0;
                for (int p = 0; p < NWR; p++) begin
                    if (wr_en[p] && wr_reg[p*RW +: RW] == idx) begin
                        val = wr_data[p*XLEN +: XLEN];
                        hit = 1'b1;
                    end
                end
                if (ZERO_REG0 && idx == '0) begin
                    val = '0;
                end
            end

            assign rd_data[gi*XLEN +: XLEN] = val;
            assign rd_hit[gi]               = hit;
        end
    endgenerate

endmodule

// File: rtl/regfile_sb.sv
// Int/float register file with power-on clear FSM and per-register pending scoreboard.
// Optional macro REGFILE_JR_PORT_EN adds a dedicated int-bank read port (jr_reg/jr_data).
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int NREG = NREG_DEFAULT,
    parameter int NRD  = 3,
    parameter int NWR  = 2,
    localparam int RW  = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rstn,
    output logic                 ready,
    input  logic [NRD-1:0]       rd_fmode,
    input  logic [NRD*RW-1:0]    rd_reg,
    output logic [NRD*XLEN-1:0]  rd_data,
    output logic [NRD-1:0]       rd_pending,
    input  logic [NWR-1:0]       wr_en,
    input  logic [NWR-1:0]       wr_fmode,
    input  logic [NWR*RW-1:0]    wr_reg,
    input  logic [NWR*XLEN-1:0]  wr_data,
    input  logic                 rsv_en,
    input  logic                 rsv_fmode,
    input  logic [RW-1:0]        rsv_reg
`ifdef REGFILE_JR_PORT_EN
    ,
    input  logic [RW-1:0]        jr_reg,
    output logic [XLEN-1:0]      jr_data
`endif
);

`ifdef REGFILE_JR_PORT_EN
    localparam int NRD_G = NRD + 1;
`else
    localparam int NRD_G = NRD;
`endif

    rf_state_t     state_reg;
    logic [RW-1:0] cnt_reg;
    logic          ready_reg;
    logic          run;

    assign run   = (state_reg == RF_RUN);
    assign ready = ready_reg;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg <= RF_INIT;
            cnt_reg   <= '0;
            ready_reg <= 1'b0;
        end else begin
            case (state_reg)
                RF_INIT: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == RW'(NREG - 1)) begin
                        state_reg <= RF_RUN;
                        ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= RF_RUN;
                end
            endcase
        end
    end

    // Writes only reach the banks in RUN; during INIT the clear port owns them.
    logic [NWR-1:0] wr_en_g, wr_en_f;
    always_comb begin
        for (int p = 0; p < NWR; p++) begin
            wr_en_g[p] = run && wr_en[p] && (wr_fmode[p] == BANK_INT);
            wr_en_f[p] = run && wr_en[p] && (wr_fmode[p] == BANK_FLT);
        end
    end

    logic [NRD_G*RW-1:0]   rd_reg_g;
    logic [NRD_G*XLEN-1:0] rd_data_g;
    logic [NRD_G-1:0]      rd_hit_g;
    logic [NRD*XLEN-1:0]   rd_data_f;
    logic [NRD-1:0]        rd_hit_f;

`ifdef REGFILE_JR_PORT_EN
    assign rd_reg_g = {jr_reg, rd_reg};
    assign jr_data  = run ? rd_data_g[NRD*XLEN +: XLEN] : '0;
`else
    assign rd_reg_g = rd_reg;
`endif

    regfile_bank #(
        .XLEN(XLEN), .NREG(NREG), .NRD(NRD_G), .NWR(NWR), .ZERO_REG0(1'b1)
    ) u_bank_g (
        .clk(clk), .clr_en(!run), .clr_idx(cnt_reg),
        .wr_en(wr_en_g), .wr_reg(wr_reg), .wr_data(wr_data),
        .rd_reg(rd_reg_g), .rd_data(rd_data_g), .rd_hit(rd_hit_g)
    );

    regfile_bank #(
        .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .ZERO_REG0(1'b0)
    ) u_bank_f (
        .clk(clk), .clr_en(!run), .clr_idx(cnt_reg),
        .wr_en(wr_en_f), .wr_reg(wr_reg), .wr_data(wr_data),
        .rd_reg(rd_reg), .rd_data(rd_data_f), .rd_hit(rd_hit_f)
    );

    // Scoreboard: writes retire a reservation, a same-cycle reservation is newer and wins.
    logic [NREG-1:0] pend_g_reg, pend_g_next;
    logic [NREG-1:0] pend_f_reg, pend_f_next;

    always_comb begin
        pend_g_next = pend_g_reg;
        pend_f_next = pend_f_reg;
        for (int p = 0; p < NWR; p++) begin
            if (wr_en_g[p]) pend_g_next[wr_reg[p*RW +: RW]] = 1'b0;
            if (wr_en_f[p]) pend_f_next[wr_reg[p*RW +: RW]] = 1'b0;
        end
        if (run && rsv_en) begin
            if (rsv_fmode == BANK_FLT) pend_f_next[rsv_reg] = 1'b1;
            else                       pend_g_next[rsv_reg] = 1'b1;
        end
        pend_g_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pend_g_reg <= '0;
            pend_f_reg <= '0;
        end else begin
            pend_g_reg <= pend_g_next;
            pend_f_reg <= pend_f_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_port
            logic [RW-1:0] idx;
            logic          pend_bit;
            logic          hit;

            assign idx      = rd_reg[gi*RW +: RW];
            assign pend_bit = rd_fmode[gi] ? pend_f_reg[idx] : pend_g_reg[idx];
            assign hit      = rd_fmode[gi] ? rd_hit_f[gi] : rd_hit_g[gi];

            assign rd_data[gi*XLEN +: XLEN] = !run ? '0 :
                rd_fmode[gi] ? rd_data_f[gi*XLEN +: XLEN] : rd_data_g[gi*XLEN +: XLEN];
            assign rd_pending[gi] = run && pend_bit && !hit;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (optionally with REGFILE_JR_PORT_EN).
module tb_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 3;
    localparam int NWR  = 2;
    localparam int RW   = 5;

    logic                clk = 1'b0;
    logic                rstn;
    logic                ready;
    logic [NRD-1:0]      rd_fmode;
    logic [NRD*RW-1:0]   rd_reg;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_pending;
    logic [NWR-1:0]      wr_en;
    logic [NWR-1:0]      wr_fmode;
    logic [NWR*RW-1:0]   wr_reg;
    logic [NWR*XLEN-1:0] wr_data;
    logic                rsv_en;
    logic                rsv_fmode;
    logic [RW-1:0]       rsv_reg;
`ifdef REGFILE_JR_PORT_EN
    logic [RW-1:0]       jr_reg;
    logic [XLEN-1:0]     jr_data;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) dut (
        .clk(clk), .rstn(rstn), .ready(ready),
        .rd_fmode(rd_fmode), .rd_reg(rd_reg), .rd_data(rd_data), .rd_pending(rd_pending),
        .wr_en(wr_en), .wr_fmode(wr_fmode), .wr_reg(wr_reg), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_fmode(rsv_fmode), .rsv_reg(rsv_reg)
`ifdef REGFILE_JR_PORT_EN
        , .jr_reg(jr_reg), .jr_data(jr_data)
`endif
    );

    task automatic set_rd(input int i, input logic f, input int r);
        logic [31:0] rv;
        rv = r;
        rd_fmode[i]         = f;
        rd_reg[i*RW +: RW]  = rv[RW-1:0];
    endtask

    task automatic set_wr(input int p, input logic en, input logic f, input int r,
                          input logic [XLEN-1:0] d);
        logic [31:0] rv;
        rv = r;
        wr_en[p]               = en;
        wr_fmode[p]            = f;
        wr_reg[p*RW +: RW]     = rv[RW-1:0];
        wr_data[p*XLEN +: XLEN] = d;
    endtask

    task automatic idle_inputs();
        wr_en  = '0;
        rsv_en = 1'b0;
    endtask

    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (cycles < 100) begin
            @(posedge clk); #1;
            cycles++;
            if (ready) break;
        end
    endtask

    task automatic test_reset();
        int cycles;
        rstn = 1'b0;
        idle_inputs();
        wr_fmode = '0; wr_reg = '0; wr_data = '0;
        rsv_fmode = 1'b0; rsv_reg = '0;
        rd_fmode = '0; rd_reg = '0;
`ifdef REGFILE_JR_PORT_EN
        jr_reg = '0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", ready); end
        checks++;
        if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data got %h exp 0", rd_data); end
        checks++;
        if (rd_pending !== '0) begin errors++; $display("FAIL reset_pending got %b exp 0", rd_pending); end
        // Writes and reservations during INIT must be ignored.
        rstn = 1'b1;
        set_wr(0, 1'b1, 1'b0, 5, 32'hDEAD);
        rsv_en = 1'b1; rsv_fmode = 1'b0; rsv_reg = 5'd6;
        set_rd(0, 1'b0, 5);
        #1;
        checks++;
        if (rd_data[31:0] !== 32'h0) begin errors++; $display("FAIL init_rd_zero got %h exp 0", rd_data[31:0]); end
        wait_ready(cycles);
        idle_inputs();
        checks++;
        if (cycles !== 32) begin errors++; $display("FAIL init_cycles got %0d exp 32", cycles); end
        @(negedge clk);
        set_rd(0, 1'b0, 5);
        set_rd(1, 1'b0, 6);
        #1;
        checks++;
        if (rd_data[31:0] !== 32'h0) begin errors++; $display("FAIL init_g5 got %h exp 0", rd_data[31:0]); end
        checks++;
        if (rd_pending[1] !== 1'b0) begin errors++; $display("FAIL init_rsv_g6 got %b exp 0", rd_pending[1]); end
        $display("reset/init: ready after %0d cycles", cycles);
    endtask

    task automatic test_bypass();
        @(negedge clk);
        set_wr(0, 1'b1, 1'b0, 7, 32'h11);
        set_wr(1, 1'b1, 1'b0, 7, 32'h22);
        set_rd(0, 1'b0, 7);
        set_rd(2, 1'b0, 7);
        #1;
        checks++;
        if (rd_data[31:0] !== 32'h22) begin errors++; $display("FAIL bypass_p0 got %h exp 22", rd_data[31:0]); end
        checks++;
        if (rd_data[95:64] !== 32'h22) begin errors++; $display("FAIL bypass_p2 got %h exp 22", rd_data[95:64]); end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (rd_data[31:0] !== 32'h22) begin errors++; $display("FAIL priority_store got %h exp 22", rd_data[31:0]); end
        $display("bypass: g7 = %h", rd_data[31:0]);
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        set_wr(0, 1'b1, 1'b0, 0, 32'hFFFFFFFF);
        set_wr(1, 1'b1, 1'b1, 0, 32'h3F800000);
        for (int i = 0; i < NRD; i++) set_rd(i, 1'b0, 0);
        #1;
        for (int i = 0; i < NRD; i++) begin
            checks++;
            if (rd_data[i*XLEN +: XLEN] !== 32'h0) begin
                errors++; $display("FAIL g0_bypass_p%0d got %h exp 0", i, rd_data[i*XLEN +: XLEN]);
            end
        end
        @(negedge clk);
        idle_inputs();
        set_rd(0, 1'b0, 0);
        set_rd(1, 1'b1, 0);
        rsv_en = 1'b1; rsv_fmode = 1'b0; rsv_reg = 5'd0;
        #1;
        checks++;
        if (rd_data[31:0] !== 32'h0) begin errors++; $display("FAIL g0_store got %h exp 0", rd_data[31:0]); end
        checks++;
        if (rd_data[63:32] !== 32'h3F800000) begin errors++; $display("FAIL f0_store got %h exp 3f800000", rd_data[63:32]); end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (rd_pending[0] !== 1'b0) begin errors++; $display("FAIL g0_pending got %b exp 0", rd_pending[0]); end
        $display("zero reg: g0 = %h f0 = %h", rd_data[31:0], rd_data[63:32]);
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        rsv_en = 1'b1; rsv_fmode = 1'b1; rsv_reg = 5'd3;
        @(negedge clk);
        idle_inputs();
        set_rd(1, 1'b1, 3);
        set_rd(0, 1'b0, 3);
        #1;
        checks++;
        if (rd_pending[1] !== 1'b1) begin errors++; $display("FAIL f3_pending got %b exp 1", rd_pending[1]); end
        checks++;
        if (rd_pending[0] !== 1'b0) begin errors++; $display("FAIL g3_not_pending got %b exp 0", rd_pending[0]); end
        @(negedge clk);
        set_wr(1, 1'b1, 1'b1, 3, 32'h40000000);
        #1;
        checks++;
        if (rd_pending[1] !== 1'b0) begin errors++; $display("FAIL f3_write_pending got %b exp 0", rd_pending[1]); end
        checks++;
        if (rd_data[63:32] !== 32'h40000000) begin errors++; $display("FAIL f3_bypass got %h exp 40000000", rd_data[63:32]); end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (rd_pending[1] !== 1'b0) begin errors++; $display("FAIL f3_cleared got %b exp 0", rd_pending[1]); end
        // Reserve and write the same register in one cycle.
        @(negedge clk);
        set_wr(0, 1'b1, 1'b0, 9, 32'h99);
        rsv_en = 1'b1; rsv_fmode = 1'b0; rsv_reg = 5'd9;
        set_rd(2, 1'b0, 9);
        #1;
        checks++;
        if (rd_pending[2] !== 1'b0) begin errors++; $display("FAIL g9_same_cycle got %b exp 0", rd_pending[2]); end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (rd_pending[2] !== 1'b1) begin errors++; $display("FAIL g9_rsv_wins got %b exp 1", rd_pending[2]); end
        checks++;
        if (rd_data[95:64] !== 32'h99) begin errors++; $display("FAIL g9_data got %h exp 99", rd_data[95:64]); end
        $display("scoreboard: g9 pending = %b", rd_pending[2]);
    endtask

    task automatic test_reset_mid();
        int cycles;
        @(negedge clk);
        set_wr(0, 1'b1, 1'b0, 4, 32'h55);
        rsv_en = 1'b1; rsv_fmode = 1'b0; rsv_reg = 5'd4;
        set_rd(0, 1'b0, 4);
        set_rd(2, 1'b0, 9);
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (rd_data[31:0] !== 32'h55 || rd_pending[0] !== 1'b1) begin
            errors++; $display("FAIL g4_before got %h/%b exp 55/1", rd_data[31:0], rd_pending[0]);
        end
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        #1;
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL midreset_ready got %b exp 0", ready); end
        wait_ready(cycles);
        checks++;
        if (cycles !== 32) begin errors++; $display("FAIL midreset_cycles got %0d exp 32", cycles); end
        @(negedge clk);
        #1;
        checks++;
        if (rd_data[31:0] !== 32'h0 || rd_pending[0] !== 1'b0) begin
            errors++; $display("FAIL g4_after got %h/%b exp 0/0", rd_data[31:0], rd_pending[0]);
        end
        checks++;
        if (rd_pending[2] !== 1'b0) begin errors++; $display("FAIL g9_after got %b exp 0", rd_pending[2]); end
        $display("reset mid-run: ready after %0d cycles", cycles);
    endtask

`ifdef REGFILE_JR_PORT_EN
    task automatic test_jr_port();
        @(negedge clk);
        set_wr(1, 1'b1, 1'b0, 31, 32'h400);
        jr_reg = 5'd31;
        #1;
        checks++;
        if (jr_data !== 32'h400) begin errors++; $display("FAIL jr_bypass got %h exp 400", jr_data); end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (jr_data !== 32'h400) begin errors++; $display("FAIL jr_store got %h exp 400", jr_data); end
        jr_reg = 5'd0;
        #1;
        checks++;
        if (jr_data !== 32'h0) begin errors++; $display("FAIL jr_g0 got %h exp 0", jr_data); end
        $display("jr port: jr_data = %h", jr_data);
    endtask
`endif

    initial begin
        test_reset();
        test_bypass();
        test_zero_reg();
        test_scoreboard();
        test_reset_mid();
`ifdef REGFILE_JR_PORT_EN
        test_jr_port();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised integer/float register file with a pending-write scoreboard, for the pipelined core.
- Two banks (int "g", float "f") with NRD read ports and NWR write ports.
- Same-cycle write-to-read bypass on every read port.
- Per-register pending bits so issue logic can detect RAW hazards against in-flight multi-cycle results.
- Power-on clear sequence clears both banks before the core may issue.

Parameters:
XLEN, 32, data width of every register
NREG, 32, registers per bank (power of two, >=2); RW = $clog2(NREG) index width
NRD, 3, number of read ports
NWR, 2, number of write ports

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
ready  out  1  high when in RUN state; issue logic must not issue while low
rd_fmode  in  NRD  per read port: 1 = float bank, 0 = int bank
rd_reg  in  NRD*RW  per read port register index, port i at bits [i*RW +: RW]
rd_data  out  NRD*XLEN  per read port data, combinational
rd_pending  out  NRD  per read port: source register has an outstanding reservation
wr_en  in  NWR  per write port enable
wr_fmode  in  NWR  per write port bank select
wr_reg  in  NWR*RW  per write port index
wr_data  in  NWR*XLEN  per write port data
rsv_en  in  1  reserve a destination, i.e. mark it pending
rsv_fmode  in  1  bank of reservation
rsv_reg  in  RW  index of reservation

Behaviour:
- State machine, states RF_INIT and RF_RUN; clear counter cnt is RW bits.
- Reset (rstn=0 at a clk edge):
  - state <= RF_INIT, cnt <= 0, all pending bits <= 0.
  - ready = 0 while state is RF_INIT.
  - Reset asserted mid-operation restarts the sequence from cnt=0.
- RF_INIT:
  - Each cycle writes 0 to g[cnt] and f[cnt], then cnt++.
  - When cnt == NREG-1 that cycle's clear completes; next state is RF_RUN. Clear takes exactly NREG cycles after rstn rises.
  - wr_en and rsv_en are ignored.
  - rd_data = 0 and rd_pending = 0 on all ports.
- RF_RUN:
  - ready = 1.
  - Write port p with wr_en[p] writes wr_data to the selected bank at the next edge.
  - Any write to int register 0 is discarded; g[0] reads 0 at all times.
  - Float register 0 is an ordinary register.
- Read port i:
  - If a write port is enabled in the same cycle with matching bank and index, and the target is not g0, rd_data is that wr_data (bypass).
  - Otherwise rd_data is the stored value.
  - If several write ports match, the highest-index port wins for bypass and for storage.
- Scoreboard, one bit per register per bank:
  - A write to a register clears its bit at the next edge.
  - rsv_en sets the bit of (rsv_fmode, rsv_reg) at the next edge.
  - Reserve and write to the same register in one cycle: the bit ends up set, because the reservation is for a newer producer.
  - A reservation of g0 is ignored; g0 is never pending.
- rd_pending[i] = pending bit of the source register AND NOT (a same-cycle write to that register). A value arriving this cycle is bypassed, so it is not a hazard.
- Latency:
  - Write to read: 0 cycles via bypass.
  - Reservation to rd_pending high: 1 cycle.
  - Write to rd_pending low: 0 cycles.

Optional Feature:
Macro REGFILE_JR_PORT_EN.
- Defined: adds ports jr_reg (in, RW) and jr_data (out, XLEN), a dedicated int-bank read for jump-register.
  - Same bypass and g0 rules as the read ports.
  - Reads 0 during RF_INIT.
  - No pending output.
- Not defined: the ports do not exist; behaviour is otherwise identical.

Decomposition:
- Package regfile_pkg:
  - XLEN_DEFAULT = 32 and NREG_DEFAULT = 32.
  - typedef enum logic {RF_INIT, RF_RUN} rf_state_t.
  - Bank-select constants BANK_INT = 1'b0, BANK_FLT = 1'b1.
- Sub-module regfile_bank holds one bank's storage, write ports, and priority/bypass read logic.
  - Parameter ZERO_REG0 hardwires index 0 to zero.
  - Instantiated twice: int bank with ZERO_REG0=1, float bank with ZERO_REG0=0.
  - Scoreboard and FSM live in regfile_sb.

Test Plan:
- Init sequence: release rstn, count cycles; ready rises exactly 32 cycles later. Meanwhile drive wr_en=1 to g5 with 0xDEAD; afterwards g5 reads 0.
- Bypass and priority: in RUN, write g7=0x11 on port0 and g7=0x22 on port1 in the same cycle. Read g7 same cycle returns 0x22, and g7 still reads 0x22 the next cycle.
- Zero register: write g0=0xFFFFFFFF and f0=0x3F800000. g0 reads 0 on every port; f0 reads 0x3F800000 next cycle; reserve g0 gives rd_pending=0.
- Scoreboard: reserve f3, then read f3 next cycle gives rd_pending=1. Write f3=0x40000000: rd_pending=0 in that cycle with rd_data=0x40000000. Reserve and write g9 in the same cycle: pending=1 afterward.
- Reset mid-run: set pending on g4 and write g4=0x55, then pulse rstn low 1 cycle. ready=0 for 32 cycles, then g4 reads 0 and pending=0.
- REGFILE_JR_PORT_EN: write g31=0x400 and read jr_reg=31 in the same cycle; jr_data=0x400. jr_reg=0 gives jr_data=0.
